// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared constants for the phase-sequenced ALU: opcode encodings,
//            bit positions inside the {N,Z,C,V} flag word, and the phase
//            indices that follow the sequencer's one-hot strobes fi0..fi5.
// Ports    : (package, none)
// Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_NOT  = 3'd5;
    localparam logic [2:0] OP_SHL1 = 3'd6;
    localparam logic [2:0] OP_SHR1 = 3'd7;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    // Expected-phase register encoding; the value equals the index of the
    // strobe the block is waiting for next.
    typedef enum logic [2:0] {
        PH0 = 3'd0,
        PH1 = 3'd1,
        PH2 = 3'd2,
        PH3 = 3'd3,
        PH4 = 3'd4,
        PH5 = 3'd5
    } phase_t;

endpackage
`default_nettype wire

// File: rtl/alu_phase_exec_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_phase_exec_if
// Purpose  : Bundles the phase strobes, instruction inputs and result outputs
//            of alu_phase_exec.
// Ports    : fi0..fi5  phase strobes (sequencer -> exec)
//            OP, A, B  opcode and operands (sequencer -> exec)
//            RES, FLAGS, END, BUSY, ERR  results and status (exec -> sequencer)
//            modport master : sequencer / bench side
//            modport slave  : execution unit side
// Revision : 1.0  initial release
// ============================================================================
interface alu_phase_exec_if #(
    parameter int WIDTH = 8
);
    logic             fi0;
    logic             fi1;
    logic             fi2;
    logic             fi3;
    logic             fi4;
    logic             fi5;
    logic [2:0]       OP;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] RES;
    logic [3:0]       FLAGS;
    logic             END;
    logic             BUSY;
    logic             ERR;

    modport master (
        output fi0, fi1, fi2, fi3, fi4, fi5, OP, A, B,
        input  RES, FLAGS, END, BUSY, ERR
    );

    modport slave (
        input  fi0, fi1, fi2, fi3, fi4, fi5, OP, A, B,
        output RES, FLAGS, END, BUSY, ERR
    );
endinterface
`default_nettype wire

// File: rtl/half_adder_slice.sv
`default_nettype none
// ============================================================================
// Module   : half_adder_slice
// Purpose  : WIDTH-bit combinational adder used for one half of the ALU word.
//            Besides the carry-out it exposes the carry into its MSB, which
//            the caller needs for signed overflow.
// Ports    : i_a, i_b   addends
//            i_cin      carry in
//            o_sum      sum bits
//            o_cout     carry out of the MSB
//            o_msb_cin  carry into the MSB
// Revision : 1.0  initial release
// ============================================================================
module half_adder_slice #(
    parameter int WIDTH = 4
) (
    input  wire logic [WIDTH-1:0] i_a,
    input  wire logic [WIDTH-1:0] i_b,
    input  wire logic             i_cin,
    output logic      [WIDTH-1:0] o_sum,
    output logic                  o_cout,
    output logic                  o_msb_cin
);
    logic [WIDTH:0] w_full;

    assign w_full    = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};
    assign o_sum     = w_full[WIDTH-1:0];
    assign o_cout    = w_full[WIDTH];
    // sum = a ^ b ^ carry_in at every bit, so the MSB carry-in falls out directly.
    assign o_msb_cin = w_full[WIDTH-1] ^ i_a[WIDTH-1] ^ i_b[WIDTH-1];
endmodule
`default_nettype wire

// File: rtl/alu_phase_exec.sv
`default_nettype none
// ============================================================================
// Module   : alu_phase_exec
// Purpose  : Executes one ALU instruction per fi0..fi5 phase sequence:
//            fi0 latch, fi1 decode, fi2/fi3 low/high half add (or full-width
//            logic op at fi2), fi4 flags, fi5 write-back with a one-cycle END.
//            Out-of-order strobes set a sticky ERR; multi-hot edges are
//            ignored apart from setting ERR. WIDTH must be even and >= 4.
// Ports    : CLK    rising-edge clock
//            RST_N  asynchronous active-low reset
//            bus    alu_phase_exec_if slave (strobes, OP/A/B, RES/FLAGS,
//                   END/BUSY/ERR)
// Revision : 1.0  initial release
// ============================================================================
module alu_phase_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input wire logic        CLK,
    input wire logic        RST_N,
    alu_phase_exec_if.slave bus
);
    localparam int HALF = WIDTH / 2;

    // ---------------- state ----------------
    phase_t           r_ph;
    logic [WIDTH-1:0] r_opa, r_opb, r_acc, r_res;
    logic [2:0]       r_op;
    logic             r_arith, r_cin, r_c_mid, r_c_out, r_c_msb;
    logic [3:0]       r_flags_pend, r_flags;
    logic             r_end, r_busy, r_err;

    phase_t           w_ph_nxt;
    logic [WIDTH-1:0] w_opa_nxt, w_opb_nxt, w_acc_nxt, w_res_nxt;
    logic [2:0]       w_op_nxt;
    logic             w_arith_nxt, w_cin_nxt, w_c_mid_nxt, w_c_out_nxt, w_c_msb_nxt;
    logic [3:0]       w_flags_pend_nxt, w_flags_nxt;
    logic             w_end_nxt, w_busy_nxt, w_err_nxt;

    // ---------------- strobe decode ----------------
    logic [5:0] w_strb;
    logic       w_any, w_multi;
    phase_t     w_k;

    assign w_strb  = {bus.fi5, bus.fi4, bus.fi3, bus.fi2, bus.fi1, bus.fi0};
    assign w_any   = (w_strb != 6'd0);
    assign w_multi = ((w_strb & (w_strb - 6'd1)) != 6'd0);

    always_comb begin
        w_k = PH0;
        for (int i = 0; i < 6; i++) begin
            if (w_strb[i]) begin
                w_k = phase_t'(3'(i));
            end
        end
    end

    // ---------------- shared half adder ----------------
    // fi2 adds the low halves with the decoded carry-in; fi3 reuses the same
    // slice on the high halves with the carry from the low half.
    logic [HALF-1:0] w_add_a, w_add_b, w_sum;
    logic            w_add_cin, w_cout, w_msb_cin;

    always_comb begin
        if (r_ph == PH3) begin
            w_add_a   = r_opa[WIDTH-1:HALF];
            w_add_b   = r_opb[WIDTH-1:HALF];
            w_add_cin = r_c_mid;
        end else begin
            w_add_a   = r_opa[HALF-1:0];
            w_add_b   = r_opb[HALF-1:0];
            w_add_cin = r_cin;
        end
    end

    half_adder_slice #(
        .WIDTH (HALF)
    ) u_slice (
        .i_a       (w_add_a),
        .i_b       (w_add_b),
        .i_cin     (w_add_cin),
        .o_sum     (w_sum),
        .o_cout    (w_cout),
        .o_msb_cin (w_msb_cin)
    );

    // ---------------- logic-class result ----------------
    logic [WIDTH-1:0] w_logic;
    logic             w_logic_c;

    always_comb begin
        w_logic   = '0;
        w_logic_c = 1'b0;
        case (r_op)
            OP_AND:  w_logic = r_opa & r_opb;
            OP_OR:   w_logic = r_opa | r_opb;
            OP_XOR:  w_logic = r_opa ^ r_opb;
            OP_NOT:  w_logic = ~r_opa;
            OP_SHL1: begin
                w_logic   = {r_opa[WIDTH-2:0], 1'b0};
                w_logic_c = r_opa[WIDTH-1];
            end
            OP_SHR1: begin
                w_logic   = {1'b0, r_opa[WIDTH-1:1]};
                w_logic_c = r_opa[0];
            end
            default: ;
        endcase
    end

    // ---------------- next-state ----------------
    always_comb begin
        w_ph_nxt         = r_ph;
        w_opa_nxt        = r_opa;
        w_opb_nxt        = r_opb;
        w_op_nxt         = r_op;
        w_arith_nxt      = r_arith;
        w_cin_nxt        = r_cin;
        w_acc_nxt        = r_acc;
        w_c_mid_nxt      = r_c_mid;
        w_c_out_nxt      = r_c_out;
        w_c_msb_nxt      = r_c_msb;
        w_flags_pend_nxt = r_flags_pend;
        w_res_nxt        = r_res;
        w_flags_nxt      = r_flags;
        w_end_nxt        = 1'b0;
        w_busy_nxt       = r_busy;
        w_err_nxt        = r_err;

        if (w_multi) begin
            w_err_nxt = 1'b1;
        end else if (w_any) begin
            if (w_strb[0]) begin
                // fi0 is always accepted and restarts any operation in flight.
                w_opa_nxt   = bus.A;
                w_opb_nxt   = bus.B;
                w_op_nxt    = bus.OP;
                w_acc_nxt   = '0;
                w_cin_nxt   = 1'b0;
                w_c_mid_nxt = 1'b0;
                w_c_out_nxt = 1'b0;
                w_c_msb_nxt = 1'b0;
                w_busy_nxt  = 1'b1;
                w_ph_nxt    = PH1;
            end else if (w_k != r_ph) begin
                w_err_nxt  = 1'b1;
                w_busy_nxt = 1'b0;
                w_ph_nxt   = PH0;
            end else begin
                case (r_ph)
                    PH1: begin
                        w_arith_nxt = (r_op == OP_ADD) || (r_op == OP_SUB);
                        // opB is replaced by its effective form in place.
                        if (r_op == OP_SUB) begin
                            w_opb_nxt = ~r_opb;
                            w_cin_nxt = 1'b1;
                        end
                        w_ph_nxt = PH2;
                    end
                    PH2: begin
                        if (r_arith) begin
                            w_acc_nxt[HALF-1:0] = w_sum;
                            w_c_mid_nxt         = w_cout;
                        end else begin
                            w_acc_nxt   = w_logic;
                            w_c_out_nxt = w_logic_c;
                        end
                        w_ph_nxt = PH3;
                    end
                    PH3: begin
                        if (r_arith) begin
                            w_acc_nxt[WIDTH-1:HALF] = w_sum;
                            w_c_out_nxt             = w_cout;
                            w_c_msb_nxt             = w_msb_cin;
                        end
                        w_ph_nxt = PH4;
                    end
                    PH4: begin
                        w_flags_pend_nxt[FLG_N] = r_acc[WIDTH-1];
                        w_flags_pend_nxt[FLG_Z] = (r_acc == '0);
                        w_flags_pend_nxt[FLG_C] = r_c_out;
                        w_flags_pend_nxt[FLG_V] = r_arith & (r_c_msb ^ r_c_out);
                        w_ph_nxt = PH5;
                    end
                    PH5: begin
                        w_res_nxt   = r_acc;
                        w_flags_nxt = r_flags_pend;
                        w_busy_nxt  = 1'b0;
                        w_end_nxt   = 1'b1;
                        w_ph_nxt    = PH0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- state register ----------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ph         <= PH0;
            r_opa        <= '0;
            r_opb        <= '0;
            r_op         <= '0;
            r_arith      <= 1'b0;
            r_cin        <= 1'b0;
            r_acc        <= '0;
            r_c_mid      <= 1'b0;
            r_c_out      <= 1'b0;
            r_c_msb      <= 1'b0;
            r_flags_pend <= '0;
            r_res        <= '0;
            r_flags      <= '0;
            r_end        <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_ph         <= w_ph_nxt;
            r_opa        <= w_opa_nxt;
            r_opb        <= w_opb_nxt;
            r_op         <= w_op_nxt;
            r_arith      <= w_arith_nxt;
            r_cin        <= w_cin_nxt;
            r_acc        <= w_acc_nxt;
            r_c_mid      <= w_c_mid_nxt;
            r_c_out      <= w_c_out_nxt;
            r_c_msb      <= w_c_msb_nxt;
            r_flags_pend <= w_flags_pend_nxt;
            r_res        <= w_res_nxt;
            r_flags      <= w_flags_nxt;
            r_end        <= w_end_nxt;
            r_busy       <= w_busy_nxt;
            r_err        <= w_err_nxt;
        end
    end

    assign bus.RES   = r_res;
    assign bus.FLAGS = r_flags;
    assign bus.END   = r_end;
    assign bus.BUSY  = r_busy;
    assign bus.ERR   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_phase_exec.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_phase_exec
// Purpose  : Directed self-checking bench for alu_phase_exec with
//            hand-computed results and flags ({N,Z,C,V}).
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_phase_exec;
    import alu_pkg::*;

    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    alu_phase_exec_if #(.WIDTH(8)) bus ();

    alu_phase_exec #(
        .WIDTH (8)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    int n_chk   = 0;
    int n_err   = 0;
    int end_cnt = 0;

    always @(posedge CLK) begin
        if (bus.END === 1'b1) end_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply a strobe pattern {fi5..fi0} now (just after an edge), then return
    // 1 time unit after the next rising edge.
    task automatic drive(input logic [5:0] s);
        {bus.fi5, bus.fi4, bus.fi3, bus.fi2, bus.fi1, bus.fi0} = s;
        @(posedge CLK);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] er, input logic [3:0] ef);
        int e0;
        e0 = end_cnt;
        bus.OP = op; bus.A = a; bus.B = b;
        drive(6'b000001);
        chk({tag, ".busy"}, 32'(bus.BUSY), 32'd1);
        drive(6'b000010);
        drive(6'b000100);
        drive(6'b001000);
        drive(6'b010000);
        drive(6'b100000);
        chk({tag, ".end"},   32'(bus.END),   32'd1);
        chk({tag, ".res"},   32'(bus.RES),   32'(er));
        chk({tag, ".flags"}, 32'(bus.FLAGS), 32'(ef));
        chk({tag, ".idle"},  32'(bus.BUSY),  32'd0);
        drive(6'b000000);
        chk({tag, ".endlo"}, 32'(bus.END),   32'd0);
        chk({tag, ".ends"},  32'(end_cnt - e0), 32'd1);
    endtask

    initial begin
        int e0;
        RST_N = 1'b0;
        bus.OP = '0; bus.A = '0; bus.B = '0;
        {bus.fi5, bus.fi4, bus.fi3, bus.fi2, bus.fi1, bus.fi0} = 6'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst.res",   32'(bus.RES),   32'd0);
        chk("rst.flags", 32'(bus.FLAGS), 32'd0);
        chk("rst.end",   32'(bus.END),   32'd0);
        chk("rst.busy",  32'(bus.BUSY),  32'd0);
        chk("rst.err",   32'(bus.ERR),   32'd0);
        RST_N = 1'b1;
        drive(6'b0);

        run_op("add_f0_20", OP_ADD,  8'hF0, 8'h20, 8'h10, 4'b0010);
        run_op("sub_5_5",   OP_SUB,  8'h05, 8'h05, 8'h00, 4'b0110);
        run_op("sub_3_5",   OP_SUB,  8'h03, 8'h05, 8'hFE, 4'b1000);
        run_op("add_7f_1",  OP_ADD,  8'h7F, 8'h01, 8'h80, 4'b1001);
        run_op("shl_81",    OP_SHL1, 8'h81, 8'h00, 8'h02, 4'b0010);
        run_op("or_0",      OP_OR,   8'h00, 8'h00, 8'h00, 4'b0100);
        run_op("not_55",    OP_NOT,  8'h55, 8'hFF, 8'hAA, 4'b1000);
        run_op("shr_01",    OP_SHR1, 8'h01, 8'h00, 8'h00, 4'b0110);
        run_op("xor",       OP_XOR,  8'hFF, 8'h0F, 8'hF0, 4'b1000);
        run_op("and",       OP_AND,  8'hF0, 8'h3C, 8'h30, 4'b0000);
        chk("clean.err", 32'(bus.ERR), 32'd0);

        // Out-of-order strobe: fi3 while fi2 is expected.
        e0 = end_cnt;
        bus.OP = OP_ADD; bus.A = 8'h11; bus.B = 8'h22;
        drive(6'b000001);
        drive(6'b000010);
        drive(6'b001000);
        chk("ooo.err",  32'(bus.ERR),  32'd1);
        chk("ooo.busy", 32'(bus.BUSY), 32'd0);
        drive(6'b000000);
        chk("ooo.res",  32'(bus.RES),  32'h30);
        chk("ooo.noend", 32'(end_cnt - e0), 32'd0);
        run_op("after_err", OP_SUB, 8'h10, 8'h01, 8'h0F, 4'b0010);
        chk("sticky.err", 32'(bus.ERR), 32'd1);

        // Async reset pulse between edges to clear ERR.
        #1 RST_N = 1'b0;
        #2 RST_N = 1'b1;
        chk("clr.err", 32'(bus.ERR), 32'd0);
        drive(6'b0);

        // Multi-hot edge ignored; operand change after fi0 has no effect.
        e0 = end_cnt;
        bus.OP = OP_ADD; bus.A = 8'h01; bus.B = 8'h01;
        drive(6'b000001);
        bus.A = 8'h00; bus.B = 8'h00; bus.OP = OP_AND;
        drive(6'b000010);
        drive(6'b001100);
        chk("multi.err",  32'(bus.ERR),  32'd1);
        chk("multi.busy", 32'(bus.BUSY), 32'd1);
        drive(6'b000100);
        drive(6'b001000);
        drive(6'b010000);
        drive(6'b100000);
        chk("multi.end",   32'(bus.END),   32'd1);
        chk("multi.res",   32'(bus.RES),   32'h02);
        chk("multi.flags", 32'(bus.FLAGS), 32'd0);
        drive(6'b0);
        chk("multi.ends",  32'(end_cnt - e0), 32'd1);

        // Asynchronous reset while fi3 is presented.
        bus.OP = OP_ADD; bus.A = 8'h01; bus.B = 8'h02;
        drive(6'b000001);
        drive(6'b000010);
        drive(6'b000100);
        {bus.fi5, bus.fi4, bus.fi3, bus.fi2, bus.fi1, bus.fi0} = 6'b001000;
        #2 RST_N = 1'b0;
        #1;
        chk("arst.res",  32'(bus.RES),  32'd0);
        chk("arst.busy", 32'(bus.BUSY), 32'd0);
        chk("arst.err",  32'(bus.ERR),  32'd0);
        chk("arst.end",  32'(bus.END),  32'd0);
        #1 {bus.fi5, bus.fi4, bus.fi3, bus.fi2, bus.fi1, bus.fi0} = 6'b0;
        #1 RST_N = 1'b1;
        @(posedge CLK);
        #1;
        chk("arst.err2", 32'(bus.ERR), 32'd0);

        // Restart by fi0 after fi2, with an idle gap that must not error.
        e0 = end_cnt;
        bus.OP = OP_ADD; bus.A = 8'h01; bus.B = 8'h02;
        drive(6'b000001);
        drive(6'b000010);
        drive(6'b000100);
        drive(6'b000000);
        chk("gap.err", 32'(bus.ERR), 32'd0);
        bus.OP = OP_XOR; bus.A = 8'hFF; bus.B = 8'h0F;
        drive(6'b000001);
        drive(6'b000010);
        drive(6'b000100);
        drive(6'b001000);
        drive(6'b010000);
        drive(6'b100000);
        chk("restart.res",   32'(bus.RES),   32'hF0);
        chk("restart.flags", 32'(bus.FLAGS), 32'b1000);
        drive(6'b000000);
        chk("restart.ends",  32'(end_cnt - e0), 32'd1);
        chk("restart.err",   32'(bus.ERR), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
